// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Program sequencer sitting directly upstream of the 8-bit ALU. It fetches
// 3-byte instructions (opcode, operand A, operand B) from program memory,
// presents them to the ALU, holds them for ALU_LAT cycles, captures the
// result and flags, posts them with a one-cycle res_valid pulse and moves on
// to the next instruction until it sees HALT (FF) or an error.
//
// Parameters
//   ADDR_W   program-memory address width; the PC wraps modulo 2^ADDR_W
//   ALU_LAT  cycles from operand issue to result sample, legal range 1..15
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, start_addr        level start request (honoured in IDLE only)
//   mem_rd, mem_addr         read request and address towards program memory
//   mem_valid, mem_rdata     read completion and data from program memory
//   alu_a, alu_b, alu_op     operands and instruction byte towards the ALU
//   alu_result/carry/comp    ALU outputs
//   res_data/carry/comp      last captured result and flags
//   res_valid                one-cycle pulse whenever res_* update
//   busy, halted, err        status: running / stopped in HALT / sticky error
//   fsm_state                current FSM state, for observation only
//
// Read handshake: mem_rd is raised the cycle after a fetch state is entered
// and then held, with mem_addr fixed, until a cycle in which mem_valid=1.
// That cycle completes the transfer (data is captured on its closing edge)
// and mem_rd is low again in the following cycle. mem_valid is ignored
// whenever mem_rd is low.
//
// Build option
//   ALU_SEQ_DIV0_TRAP_EN  when defined, a divide (04) with operand B = 0 is
//                         not issued: err is set and the sequencer halts
//                         without touching res_*. When undefined the divide
//                         is issued like any other instruction.
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int ALU_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [7:0]        alu_op,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    input  logic              alu_comp,
    output logic [7:0]        res_data,
    output logic              res_carry,
    output logic              res_comp,
    output logic              res_valid,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_F_OP  = 3'd1,
        S_F_A   = 3'd2,
        S_F_B   = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT  = 3'd5,
        S_WB    = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    localparam logic [7:0] OP_DIV  = 8'h04;
    localparam logic [7:0] OP_HALT = 8'hFF;

    // Four bits cover the whole legal ALU_LAT range (1..15).
    localparam int              CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(ALU_LAT - 1);

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] pc;
    logic [7:0]        op_q;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic              fetching;
    logic              fetch_done;
    logic              op_illegal;
    logic              div0_trap;

    // Opcodes 01..08 are ALU instructions, FF is HALT, everything else is
    // illegal (including 00, which the ALU treats as a no-op).
    function automatic logic is_alu_op(input logic [7:0] op);
        return (op >= 8'h01) && (op <= 8'h08);
    endfunction

    // A transfer completes only while the request is actually raised, so a
    // stray mem_valid (no request, or after an abandoned read) is dropped.
    assign fetch_done = mem_rd && mem_valid;
    assign op_illegal = !is_alu_op(mem_rdata) && (mem_rdata != OP_HALT);
    assign mem_addr   = pc;

    // Evaluated while operand B is on the bus, with the opcode already held.
`ifdef ALU_SEQ_DIV0_TRAP_EN
    assign div0_trap = (op_q == OP_DIV) && (mem_rdata == 8'h00);
`else
    assign div0_trap = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_F_OP;
                end
            end
            S_F_OP: begin
                if (fetch_done) begin
                    if ((mem_rdata == OP_HALT) || op_illegal) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_F_A;
                    end
                end
            end
            S_F_A: begin
                if (fetch_done) begin
                    state_next = S_F_B;
                end
            end
            S_F_B: begin
                if (fetch_done) begin
                    state_next = div0_trap ? S_HALT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                state_next = S_F_OP;
            end
            S_HALT: begin
                // Only reset leaves HALT; start is deliberately ignored.
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        fetching  = (state == S_F_OP) || (state == S_F_A) || (state == S_F_B);
        busy      = (state != S_IDLE) && (state != S_HALT);
        halted    = (state == S_HALT);
        fsm_state = state;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            mem_rd    <= 1'b0;
            op_q      <= 8'h00;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            wait_cnt  <= '0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_op    <= 8'h00;
            res_data  <= 8'h00;
            res_carry <= 1'b0;
            res_comp  <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            res_valid <= 1'b0;

            // Low on the first cycle of a fetch state, high until the
            // completing cycle, low again right after it. Every fetch state
            // is therefore entered with the request low.
            mem_rd <= fetching && !fetch_done;

            if ((state == S_IDLE) && start) begin
                pc <= start_addr;
            end else if (fetch_done) begin
                pc <= pc + ADDR_W'(1);
            end

            case (state)
                S_F_OP: begin
                    if (fetch_done) begin
                        op_q <= mem_rdata;
                        if (op_illegal) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_F_A: begin
                    if (fetch_done) begin
                        a_q <= mem_rdata;
                    end
                end
                S_F_B: begin
                    if (fetch_done) begin
                        b_q <= mem_rdata;
                        if (div0_trap) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // The only place the ALU-facing registers change, so the
                    // ALU sees a stable instruction for the whole WAIT span
                    // and after halting keeps the last one issued.
                    alu_a    <= a_q;
                    alu_b    <= b_q;
                    alu_op   <= op_q;
                    wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_WB: begin
                    res_data  <= alu_result;
                    res_carry <= alu_carry;
                    res_comp  <= alu_comp;
                    res_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Bench for alu_sequencer. Program memory and the ALU are modelled around the
// DUT: the memory answers read requests after a programmable number of wait
// cycles (optionally toggling mem_valid at random while no read is pending),
// and the ALU presents a poison value until its inputs have been stable for
// ALU_LAT cycles. Expected results come from an instruction-level model that
// walks the program bytes and computes each result directly.
// Honours ALU_SEQ_DIV0_TRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int ALU_LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic       mem_valid = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_op;
    logic [7:0] alu_result = 8'h00;
    logic       alu_carry = 1'b0;
    logic       alu_comp = 1'b0;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_comp;
    logic       res_valid;
    logic       busy;
    logic       halted;
    logic       err;
    logic [2:0] fsm_state;

    alu_sequencer #(
        .ADDR_W (8),
        .ALU_LAT(ALU_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .alu_carry (alu_carry),
        .alu_comp  (alu_comp),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_comp  (res_comp),
        .res_valid (res_valid),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // ---------------- ALU behaviour ({carry, comp, result}) ----------------
    function automatic logic [9:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [8:0]  s;
        logic [7:0]  r;
        logic        c;
        r = 8'h00;
        c = 1'b0;
        case (op)
            8'h01: r = a;
            8'h02: r = b;
            8'h03: begin p = 16'(a) * 16'(b); r = p[7:0]; c = (p[15:8] != 8'h00); end
            8'h04: begin
                if (b == 8'h00) begin r = 8'hFF; c = 1'b1; end
                else r = a / b;
            end
            8'h05: r = a << b[2:0];
            8'h06: r = a >> b[2:0];
            8'h07: begin s = 9'(a) + 9'(b); r = s[7:0]; c = s[8]; end
            8'h08: r = (a < b) ? (b - a) : (a - b);
            default: r = 8'h00;
        endcase
        return {c, (a < b), r};
    endfunction

    // ALU with latency: poison until the inputs have been steady long enough.
    logic [23:0] alu_prev = 24'h0;
    int          alu_age  = 0;
    always @(negedge clk) begin
        if ({alu_op, alu_a, alu_b} != alu_prev) begin
            alu_prev = {alu_op, alu_a, alu_b};
            alu_age  = 1;
        end else if (alu_age < 1000) begin
            alu_age++;
        end
        if (alu_age >= ALU_LAT) {alu_carry, alu_comp, alu_result} = alu_fn(alu_op, alu_a, alu_b);
        else {alu_carry, alu_comp, alu_result} = 10'h3EE;
    end

    // ---------------- program memory ----------------
    logic [7:0] mem [256];
    int         wait_n    = 0;
    bit         noise_en  = 1'b0;
    int         rd_age    = 0;
    logic [7:0] rd_addr_q = 8'h00;
    logic [7:0] hs_addr   = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            rd_age    = 0;
            mem_valid = 1'b0;
        end else if (mem_rd) begin
            if (rd_age == 0) rd_addr_q = mem_addr;
            else check("mem_addr_stable", 64'(mem_addr), 64'(rd_addr_q));
            mem_valid = (rd_age >= wait_n);
            mem_rdata = mem_valid ? mem[mem_addr] : 8'($urandom);
            if (mem_valid) hs_addr = mem_addr;
            rd_age++;
        end else begin
            rd_age    = 0;
            mem_valid = noise_en && ($urandom_range(0, 1) == 1);
            mem_rdata = 8'($urandom);
        end
    end

    task automatic fill_noise();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic load_random_program(input logic [7:0] saddr);
        logic [7:0] p;
        int         n;
        p = saddr;
        n = $urandom_range(1, 5);
        fill_noise();
        for (int i = 0; i < n; i++) begin
            mem[p] = 8'($urandom_range(1, 8)); p++;
            mem[p] = 8'($urandom);             p++;
            mem[p] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom); p++;
        end
        mem[p] = ($urandom_range(0, 2) == 0) ? 8'h2A : 8'hFF;
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [9:0]  exp_q[$];
    logic        exp_err;
    logic [23:0] exp_alu;
    logic [9:0]  exp_res;
    logic [7:0]  exp_last_fetch;

    task automatic model_run(input logic [7:0] saddr);
        logic [7:0] pc;
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [9:0] r;
        pc = saddr;
        exp_q.delete();
        exp_err = 1'b0;
        exp_alu = 24'h0;
        exp_res = 10'h0;
        for (int k = 0; k < 64; k++) begin
            op = mem[pc]; exp_last_fetch = pc; pc++;
            if (op == 8'hFF) break;
            if (op == 8'h00 || op > 8'h08) begin exp_err = 1'b1; break; end
            a = mem[pc]; pc++;
            b = mem[pc]; exp_last_fetch = pc; pc++;
`ifdef ALU_SEQ_DIV0_TRAP_EN
            if (op == 8'h04 && b == 8'h00) begin exp_err = 1'b1; break; end
`endif
            r = alu_fn(op, a, b);
            exp_q.push_back(r);
            exp_alu = {op, a, b};
            exp_res = r;
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({mem_rd, mem_addr, alu_op, alu_a, alu_b, res_data,
                    res_carry, res_comp, res_valid, busy, halted, err});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("reset_outputs", all_outputs(), 64'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] saddr);
        @(negedge clk);
        start      = 1'b1;
        start_addr = saddr;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs a program from IDLE to HALT and checks every posted result,
    // the spacing between results, and the state left behind in HALT.
    task automatic run_program(input logic [7:0] saddr, input int wn, input bit chaos);
        logic [9:0] e;
        int         cyc;
        int         last;
        int         inst_cyc;
        bit         done;
        model_run(saddr);
        wait_n   = wn;
        noise_en = chaos;
        inst_cyc = 3 * (2 + wn) + ALU_LAT + 2;
        pulse_start(saddr);
        check("busy_after_start", 64'(busy), 64'h1);
        cyc  = 0;
        last = 0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_valid", 64'(res_valid), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'({res_carry, res_comp, res_data}), 64'(e));
                    check("instr_cycles", 64'(cyc - last), 64'(inst_cyc));
                end
                last = cyc;
            end
            if (halted) begin
                done = 1'b1;
            end else begin
                if (chaos) begin
                    start      = ($urandom_range(0, 1) == 1);
                    start_addr = 8'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("halt_reached", 64'(done), 64'h1);
        check("missing_results", 64'(exp_q.size()), 64'h0);
        check("err", 64'(err), 64'(exp_err));
        check("alu_hold", 64'({alu_op, alu_a, alu_b}), 64'(exp_alu));
        check("res_hold", 64'({res_carry, res_comp, res_data}), 64'(exp_res));
        check("last_fetch_addr", 64'(hs_addr), 64'(exp_last_fetch));
        for (int i = 0; i < 3; i++) begin
            start      = 1'b1;
            start_addr = 8'($urandom);
            @(negedge clk);
            check("halt_sticky", 64'({halted, busy, mem_rd}), 64'b100);
        end
        start = 1'b0;
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        do_reset();

        // add 5+3, then halt
        fill_noise();
        mem[8'h00] = 8'h07; mem[8'h01] = 8'h05; mem[8'h02] = 8'h03; mem[8'h03] = 8'hFF;
        run_program(8'h00, 0, 1'b0);
        check("add_res_data", 64'(res_data), 64'h08);
        check("add_no_err", 64'({halted, err}), 64'b10);

        // sub with compare, then add with carry
        do_reset();
        fill_noise();
        mem[8'h00] = 8'h08; mem[8'h01] = 8'h03; mem[8'h02] = 8'h07;
        mem[8'h03] = 8'h07; mem[8'h04] = 8'hFF; mem[8'h05] = 8'h02;
        mem[8'h06] = 8'hFF;
        run_program(8'h00, 0, 1'b0);
        check("carry_res", 64'({res_carry, res_data}), 64'h101);

        // slow memory: four wait states per read, noisy mem_valid
        do_reset();
        load_random_program(8'h40);
        run_program(8'h40, 4, 1'b1);

        // instruction straddling the top address
        do_reset();
        fill_noise();
        mem[8'hFE] = 8'h03; mem[8'hFF] = 8'h04; mem[8'h00] = 8'h05; mem[8'h01] = 8'hFF;
        run_program(8'hFE, 0, 1'b0);
        check("wrap_res_data", 64'(res_data), 64'h14);
        check("wrap_next_fetch", 64'(hs_addr), 64'h01);

        // illegal opcode
        do_reset();
        fill_noise();
        mem[8'h20] = 8'h2A;
        run_program(8'h20, 0, 1'b0);
        check("illegal_op", 64'({halted, err, res_data}), 64'h300);

        // divide by zero
        do_reset();
        fill_noise();
        mem[8'h30] = 8'h04; mem[8'h31] = 8'h09; mem[8'h32] = 8'h00; mem[8'h33] = 8'hFF;
        run_program(8'h30, 1, 1'b0);

        // reset in the middle of WAIT, then a clean restart
        do_reset();
        fill_noise();
        mem[8'h50] = 8'h07; mem[8'h51] = 8'h01; mem[8'h52] = 8'h02; mem[8'h53] = 8'hFF;
        wait_n   = 0;
        noise_en = 1'b0;
        pulse_start(8'h50);
        repeat (8) @(negedge clk);
        check("in_wait_alu_op", 64'({alu_op, alu_a, alu_b}), 64'h070102);
        #1 rst = 1'b1;
        #1 check("reset_in_wait", all_outputs(), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_program(8'h50, 0, 1'b0);

        // reset during a pending read, stray mem_valid afterwards
        do_reset();
        load_random_program(8'h80);
        wait_n   = 4;
        noise_en = 1'b0;
        pulse_start(8'h80);
        repeat (3) @(negedge clk);
        check("read_pending", 64'(mem_rd), 64'h1);
        #1 rst = 1'b1;
        #1 check("reset_in_fetch", all_outputs(), 64'h0);
        noise_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_reset", all_outputs(), 64'h0);
        run_program(8'h80, 2, 1'b1);

        // random programs
        for (int t = 0; t < 8; t++) begin
            logic [7:0] sa;
            int         wn;
            do_reset();
            sa = 8'($urandom);
            wn = $urandom_range(0, 3);
            load_random_program(sa);
            run_program(sa, wn, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Program sequencer directly upstream of the 8-bit ALU.
- Fetches each 3-byte instruction (opcode, operand A, operand B) from program memory over a valid/ready read handshake.
- Presents the operands and opcode to the ALU and holds them stable for a fixed ALU latency.
- Captures the ALU result and carry/compare flags, posts them with a one-cycle valid pulse, then advances to the next instruction until HALT or an error.

## Interface
- `ADDR_W`, 8: program-memory address width; PC wraps modulo 2^ADDR_W.
- `ALU_LAT`, 3: cycles from operand issue to result sample; legal range 1..15.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level; in IDLE, begins execution at `start_addr`.
- `start_addr` in ADDR_W: first instruction address, sampled when `start` is accepted.
- `mem_rd` out 1: read request.
- `mem_addr` out ADDR_W: read address, stable while `mem_rd`=1.
- `mem_valid` in 1: read data valid; completes the handshake.
- `mem_rdata` in 8: read data.
- `alu_a` out 8, `alu_b` out 8: ALU operands.
- `alu_op` out 8: ALU instruction byte.
- `alu_result` in 8, `alu_carry` in 1, `alu_comp` in 1: ALU outputs.
- `res_data` out 8: last captured result.
- `res_carry` out 1, `res_comp` out 1: last captured flags.
- `res_valid` out 1: one-cycle pulse when `res_*` update.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `err` out 1: sticky; set on illegal opcode (or divide-by-zero, see Configuration).

## Operation
- Opcode table, shared with the ALU: 01 loadA, 02 loadB, 03 multiply, 04 divide, 05 shiftLeft, 06 shiftRight, 07 add, 08 sub, FF halt.
- Any other opcode value is illegal.
- States: IDLE, F_OP, F_A, F_B, ISSUE, WAIT, WB, HALT.
- IDLE --start--> F_OP; PC ← `start_addr`.
- Each F_x state: assert `mem_rd` with `mem_addr`=PC. On `mem_valid`, capture `mem_rdata`, PC ← PC+1, and go to the next state.
- F_OP → F_A → F_B → ISSUE.
- In F_OP, opcode FF → HALT with no further fetch.
- In F_OP, an illegal opcode → HALT with `err` set.
- ISSUE: drive `alu_a`/`alu_b`/`alu_op` from the captured bytes, load the wait counter with ALU_LAT-1, go to WAIT.
- WAIT: decrement the counter; at 0 go to WB. `alu_*` held constant throughout.
- WB: sample `alu_result`/`alu_carry`/`alu_comp` into `res_*`, pulse `res_valid`, go to F_OP.
- HALT: remains until `rst`. `start` is ignored in HALT.
- `start` is ignored while `busy`.
- PC arithmetic is modulo 2^ADDR_W; an instruction straddling the top address wraps to 0.
- `mem_valid` while `mem_rd`=0 is ignored.

## Timing
- Reset values: state IDLE, PC 0, `mem_rd` 0, `mem_addr` 0, `alu_a`/`alu_b` 0, `alu_op` 00 (no-op to ALU), `res_data` 0, `res_carry`/`res_comp` 0, `res_valid` 0, `busy` 0, `halted` 0, `err` 0.
- Read handshake:
  - `mem_rd` rises the cycle after entering F_x.
  - `mem_rd` stays high with `mem_addr` fixed until the cycle `mem_valid`=1.
  - `mem_rd` drops the following cycle.
  - Unbounded wait states are permitted.
- With zero-wait memory (`mem_valid` on the first cycle of `mem_rd`), one instruction takes 3×2 fetch + 1 ISSUE + ALU_LAT + 1 WB cycles. Default: 11 cycles.
- `res_valid` is high exactly one cycle per executed instruction. `res_*` hold until the next WB.
- `alu_*` change only in ISSUE and otherwise hold their last value, including in HALT.
- `rst` asserted mid-fetch or mid-WAIT immediately returns all outputs to reset values. The outstanding read is abandoned, and a late `mem_valid` is ignored.

## Configuration
- `ALU_SEQ_DIV0_TRAP_EN` defined: opcode 04 with operand B = 0 skips ISSUE/WAIT/WB, sets `err`, and enters HALT. `res_*` are unchanged and `res_valid` does not pulse.
- Macro undefined: divide-by-zero is issued to the ALU like any other instruction, and the result is whatever the ALU returns.

## Test plan
- Program at 0x00: 07 05 03, FF. Zero-wait memory, ALU model result = a+b after 3 cycles. Expect `res_data`=08 with `res_valid` at cycle 11, then `halted`=1, `err`=0.
- Program at 0x00: 08 03 07, then 07 FF 02. Expect `res_data`=04, `res_comp`=1; then `res_data`=01, `res_carry`=1.
- Memory inserting 4 wait cycles per read: `mem_addr` stable while `mem_rd`=1, and exactly one `res_valid` per instruction.
- `start_addr`=FE, program 03 04 05 spanning FE, FF, 00: PC wraps, `res_data`=14, next fetch at 01.
- Opcode 2A: `halted`=1, `err`=1, no `res_valid`.
- Opcode 04 with B=00: with the macro, `err`=1 and halt; without it, the instruction executes.
- Assert `rst` during WAIT: all outputs return to reset values in the same cycle, then `start` restarts cleanly.
